speech_sequencer: RTL

- Buffers a stream of 6-bit phoneme codes from a host (menu/ATM control logic) and feeds them one at a time to the chatter voice block over its data/write/busy interface.
- Owns the handshake with chatter: issues a single-cycle write only when chatter is idle, confirms acceptance via busy, and waits for phoneme completion before issuing the next code.
- Lets the host queue a whole phrase (e.g. "ENTER PIN") in one burst instead of polling busy per phoneme.

---
 rtl/speech_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/speech_sequencer.sv
// speech_sequencer: phoneme FIFO in front of the chatter voice block.
// The host bursts whole phrases into the FIFO; a small FSM hands codes to
// chatter one at a time, issuing a single-cycle write only while chatter is
// idle, confirming acceptance via busy, and waiting for the phoneme to end.
// All outputs are registered.
module speech_sequencer #(
    parameter int DEPTH    = 16,   // power of two, 2..64
    parameter int ACK_WAIT = 8     // cycles allowed for busy to rise, 1..255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [5:0]               chat_data,
    output logic                     chat_write,
    input  logic                     chat_busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     active,
    output logic                     ack_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [7:0]    ACK_LAST = 8'(ACK_WAIT - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [5:0]      mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [7:0]      ack_cnt, ack_cnt_nxt;
    logic [LW-1:0]   level_nxt;
    logic            push, pop;
    logic            write_nxt, timeout_nxt;

    // in_ready is the registered !full, so a push is judged against it
    assign push = in_valid && in_ready;

    // Occupancy: flush wins over everything, including a same-cycle push
    always_comb begin
        level_nxt = level + LW'(push) - LW'(pop);
        if (flush)
            level_nxt = '0;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next-state: issue only when chatter is idle and nothing is being flushed
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (level != '0 && !chat_busy && !flush) state_nxt = WAIT_ACK;
            WAIT_ACK:  if (chat_busy)               state_nxt = WAIT_DONE;
                       else if (ack_cnt == ACK_LAST) state_nxt = IDLE;
            WAIT_DONE: if (!chat_busy)              state_nxt = IDLE;
            default:                                state_nxt = IDLE;
        endcase
    end

    // FSM outputs: pop/write on issue, ack counter and timeout pulse while waiting
    always_comb begin
        pop         = 1'b0;
        write_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        ack_cnt_nxt = ack_cnt;
        case (state)
            IDLE: begin
                if (state_nxt == WAIT_ACK) begin
                    pop         = 1'b1;
                    write_nxt   = 1'b1;
                    ack_cnt_nxt = '0;
                end
            end
            WAIT_ACK: begin
                // A dropped code is never re-issued; the FSM just gives up on it
                if (!chat_busy) begin
                    if (ack_cnt == ACK_LAST)
                        timeout_nxt = 1'b1;
                    else
                        ack_cnt_nxt = ack_cnt + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Ack counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ack_cnt <= '0;
        else
            ack_cnt <= ack_cnt_nxt;
    end

    // FIFO storage; no reset needed, contents are only read when level > 0
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= in_data;
    end

    // FIFO pointers, occupancy and ready; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            // On flush, collapse the write pointer onto the (post-pop) read pointer
            if (flush)
                wr_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            else if (push)
                wr_ptr <= wr_ptr + 1'b1;
            level    <= level_nxt;
            in_ready <= (level_nxt != FULL_LVL);
        end
    end

    // Registered chatter-side and status outputs; chat_data holds between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chat_data   <= '0;
            chat_write  <= 1'b0;
            ack_timeout <= 1'b0;
            active      <= 1'b0;
        end else begin
            if (write_nxt)
                chat_data <= mem[rd_ptr];
            chat_write  <= write_nxt;
            ack_timeout <= timeout_nxt;
            active      <= (level_nxt != '0) || (state_nxt != IDLE);
        end
    end

endmodule
